// File: rtl/edge_event_pkg.sv
// Shared types for the pushbutton edge event filter.
package edge_event_pkg;

  // Classified event presented to the system controller.
  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_SINGLE = 2'b01,
    EV_DOUBLE = 2'b10
  } ev_type_t;

  // Press classification sequence.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK1 = 2'b01,
    WAIT2 = 2'b10,
    LOCK2 = 2'b11
  } state_t;

endpackage

// File: rtl/cycle_timer.sv
// Cycle counter with synchronous clear, enable and a compare against a port value.
// Clear and enable together load 1, so a restarting sequence is already at k=1
// in the cycle after its accepting edge.
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_cmp,
  output logic         o_match
);

  logic [W-1:0] r_count;

  // Count register: clear zeroes, enable adds one on top of the (possibly cleared) value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clr || i_en) begin
      r_count <= (i_clr ? '0 : r_count) + W'(i_en);
    end
  end

  assign o_match = (r_count == i_cmp);

endmodule

// File: rtl/edge_event_filter.sv
// Debounces edge_det pulses with a lockout window, classifies presses as SINGLE or
// DOUBLE, and hands events out through a one-entry valid/ready holding register with
// a saturating load count and a sticky drop flag.
module edge_event_filter
  import edge_event_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES    = 12000,
  parameter int unsigned DOUBLE_WIN_CYCLES = 3600000,
  parameter int unsigned CNT_W             = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             edge_det,
  input  logic             clr,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [1:0]       ev_type,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow
);

  localparam int unsigned TW = $clog2(DOUBLE_WIN_CYCLES + 1);
  localparam logic [TW-1:0] LockLast = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] WinLast  = TW'(DOUBLE_WIN_CYCLES - 1);

  state_t           r_state;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic             w_match;
  logic [TW-1:0]    w_cmp;
  logic             w_emit;
  ev_type_t         w_emit_type;
  logic             w_xfer;
  logic             w_load;

  logic             r_valid;
  ev_type_t         r_type;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_cmp   (w_cmp),
    .o_match (w_match)
  );

  // Timer control and event decision for the current state; an edge in the last
  // window cycle takes priority over the timeout.
  always_comb begin
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    w_cmp       = LockLast;
    w_emit      = 1'b0;
    w_emit_type = EV_NONE;
    unique case (r_state)
      IDLE: begin
        w_tmr_clr = 1'b1;
        w_tmr_en  = edge_det;
      end
      LOCK1: begin
        w_tmr_en = 1'b1;
      end
      WAIT2: begin
        w_cmp    = WinLast;
        w_tmr_en = 1'b1;
        if (edge_det) begin
          w_tmr_clr   = 1'b1;
          w_emit      = 1'b1;
          w_emit_type = EV_DOUBLE;
        end else if (w_match) begin
          w_tmr_clr   = 1'b1;
          w_tmr_en    = 1'b0;
          w_emit      = 1'b1;
          w_emit_type = EV_SINGLE;
        end
      end
      LOCK2: begin
        w_tmr_en = 1'b1;
        if (w_match) begin
          w_tmr_clr = 1'b1;
          w_tmr_en  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Press classification state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (edge_det) r_state <= LOCK1;
        LOCK1:   if (w_match) r_state <= WAIT2;
        WAIT2: begin
          if (edge_det)     r_state <= LOCK2;
          else if (w_match) r_state <= IDLE;
        end
        LOCK2:   if (w_match) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_xfer = r_valid & ev_ready;
  // A full register that is draining this cycle can take the new event with no bubble.
  assign w_load = w_emit & (~r_valid | w_xfer);

  // Holding register, load counter and sticky drop flag; clr wins over same-cycle updates.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid <= 1'b0;
      r_type  <= EV_NONE;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_type  <= w_emit_type;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
        r_type  <= EV_NONE;
      end
      if (clr) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_load && (r_count != '1)) r_count <= r_count + CNT_W'(1);
        if (w_emit && !w_load)         r_ovf   <= 1'b1;
      end
    end
  end

  assign ev_valid = r_valid;
  assign ev_type  = r_type;
  assign ev_count = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_edge_event_filter.sv
// Scoreboard bench for edge_event_filter: a timing-rule model pushes expected events,
// a negedge monitor pops them on every handshake transfer.
module tb_edge_event_filter;
  import edge_event_pkg::*;

  localparam int unsigned LO = 4;
  localparam int unsigned DW = 20;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          edge_det = 1'b0;
  logic          clr = 1'b0;
  logic          ev_ready = 1'b0;
  logic          ev_valid;
  logic [1:0]    ev_type;
  logic [CW-1:0] ev_count;
  logic          overflow;

  edge_event_filter #(
    .LOCKOUT_CYCLES    (LO),
    .DOUBLE_WIN_CYCLES (DW),
    .CNT_W             (CW)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .edge_det (edge_det),
    .clr      (clr),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_type  (ev_type),
    .ev_count (ev_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: absolute cycle numbers of the pending first press and of the
  // end of the current lockout, plus a behavioural view of the output register.
  int            t = 0;
  bit            pend = 0;
  int            f = 0;
  int            busy_until = 0;
  bit            m_valid = 0;
  logic [CW-1:0] m_count = '0;
  bit            m_ovf = 0;
  logic [1:0]    exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
  endtask

  task automatic model_reset();
    pend = 0;
    busy_until = t;
    m_valid = 0;
    m_count = '0;
    m_ovf = 0;
    exp_q.delete();
  endtask

  // Applies one sampled cycle of inputs to the model.
  task automatic model(input bit e, input bit r, input bit c);
    logic [1:0] ev;
    bit xfer;
    ev = EV_NONE;
    xfer = m_valid && r;
    if (pend && e && (t - f) >= int'(LO)) begin
      ev = EV_DOUBLE;
      pend = 0;
      busy_until = t + int'(LO);
    end else if (pend && (t - f) == int'(DW) - 1) begin
      ev = EV_SINGLE;
      pend = 0;
      busy_until = t + 1;
    end else if (!pend && e && t >= busy_until) begin
      pend = 1;
      f = t;
    end
    if (ev != EV_NONE) begin
      if (!m_valid || xfer) begin
        m_valid = 1;
        exp_q.push_back(ev);
        if (m_count != '1) m_count = m_count + 1'b1;
      end else begin
        m_ovf = 1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
    if (c) begin
      m_count = '0;
      m_ovf = 0;
    end
  endtask

  // One clock: drive, model, advance, compare registered state.
  task automatic step(input bit e, input bit r, input bit c);
    edge_det = e;
    ev_ready = r;
    clr = c;
    model(e, r, c);
    @(posedge clk);
    #1;
    t++;
    chk("ev_valid", ev_valid, m_valid);
    chk("ev_count", ev_count, m_count);
    chk("overflow", overflow, m_ovf);
    if (!ev_valid) chk("ev_type_idle", ev_type, EV_NONE);
  endtask

  task automatic play(input logic [63:0] mask, input int len, input bit r);
    for (int i = 0; i < len; i++) step(mask[i], r, 1'b0);
  endtask

  // Monitor: every handshake transfer must deliver the oldest expected event.
  always @(negedge clk) begin
    if (n_rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_transfer: got type %0h expected no event (cycle %0d)",
                 ev_type, t);
      end else begin
        chk("ev_type_xfer", ev_type, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Asynchronous reset between edges.
    #3 n_rst = 1'b0;
    #1;
    chk("rst_valid", ev_valid, 0);
    chk("rst_type", ev_type, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_ovf", overflow, 0);
    edge_det = 1'b1;
    @(posedge clk);
    #1 edge_det = 1'b0;
    @(posedge clk);
    #3 n_rst = 1'b1;
    model_reset();
    play(64'h0, 30, 1'b1);

    // Bounced single press.
    play((64'h1 << 0) | (64'h1 << 1) | (64'h1 << 3), 25, 1'b1);
    // Double, ignored edge in LOCK2, then a fresh single.
    play((64'h1 << 0) | (64'h1 << 10) | (64'h1 << 12) | (64'h1 << 14), 40, 1'b1);
    // Edge in the last window cycle, then edge right after a timeout.
    play((64'h1 << 0) | (64'h1 << 19), 30, 1'b1);
    play((64'h1 << 0) | (64'h1 << 20), 45, 1'b1);

    // Backpressure: second single dropped, then drain and clear.
    play((64'h1 << 0) | (64'h1 << 40), 64, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Saturation, with clr on the cycle of the fourth load.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      for (int j = 1; j < int'(DW); j++) step(1'b0, 1'b1, (i == 3) && (j == int'(DW) - 1));
    end
    play(64'h0, 5, 1'b1);

    // Reset mid-sequence with an event held.
    play(64'h1, 22, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_valid", ev_valid, 0);
    chk("midrst_type", ev_type, 0);
    chk("midrst_count", ev_count, 0);
    chk("midrst_ovf", overflow, 0);
    edge_det = 1'b1;
    @(posedge clk);
    #1 edge_det = 1'b0;
    @(posedge clk);
    #3 n_rst = 1'b1;
    model_reset();
    play(64'h0, 30, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end

    play(64'h0, 30, 1'b1);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
